// File: rtl/serial_parity_rx.sv
// Serial frame receiver: start bit, DATA_W data bits LSB first, parity bit, stop bit, into one holding register.
// Parity sense: even by default; odd when SERIAL_PARITY_ODD_EN is defined.
module serial_parity_rx #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_bit,
    input  logic              rx_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              par_err,
    output logic              frm_err,
    output logic              ovr_err,
    output logic              busy
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

`ifdef SERIAL_PARITY_ODD_EN
    localparam logic PARITY_OK = 1'b1;
`else
    localparam logic PARITY_OK = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shift_reg;
    logic              acc;

    // The holding register may take a new frame if empty or being emptied this cycle.
    logic can_load;
    assign can_load = !out_valid || out_ready;

    // NOTE: all state uses non-blocking assignments so every branch reads pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shift_reg <= '0;
            acc       <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            par_err   <= 1'b0;
            frm_err   <= 1'b0;
            ovr_err   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            ovr_err <= 1'b0;
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            if (rx_valid) begin
                case (state)
                    IDLE: begin
                        if (!rx_bit) begin
                            state   <= DATA;
                            busy    <= 1'b1;
                            bit_cnt <= '0;
                            acc     <= 1'b0;
                        end
                    end
                    DATA: begin
                        shift_reg <= {rx_bit, shift_reg[DATA_W-1:1]};
                        acc       <= acc ^ rx_bit;
                        bit_cnt   <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT) begin
                            state <= PARITY;
                        end
                    end
                    PARITY: begin
                        acc   <= acc ^ rx_bit;
                        state <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (can_load) begin
                            out_valid <= 1'b1;
                            out_data  <= shift_reg;
                            par_err   <= (acc != PARITY_OK);
                            frm_err   <= !rx_bit;
                        end else begin
                            // Holding register still owned by the consumer: drop this frame.
                            ovr_err <= 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serial_parity_rx.sv
// Scoreboard bench for serial_parity_rx: expected frames are queued at stimulus time and
// compared when the consumer accepts them.
module tb_serial_parity_rx;

    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              rx_bit = 1'b1;
    logic              rx_valid = 1'b0;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              par_err;
    logic              frm_err;
    logic              ovr_err;
    logic              busy;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              par_err;
        logic              frm_err;
    } frame_t;

    frame_t exp_q[$];
    frame_t mon_exp;
    int checks = 0;
    int passed = 0;
    int valid_cycles = 0;
    int ovr_count = 0;

    serial_parity_rx #(.DATA_W(DATA_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_bit   (rx_bit),
        .rx_valid (rx_valid),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .par_err  (par_err),
        .frm_err  (frm_err),
        .ovr_err  (ovr_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    function automatic logic exp_par_err(input logic [DATA_W-1:0] d, input logic p);
        logic a;
        a = (^d) ^ p;
`ifdef SERIAL_PARITY_ODD_EN
        return a != 1'b1;
`else
        return a != 1'b0;
`endif
    endfunction

    function automatic logic good_parity(input logic [DATA_W-1:0] d);
`ifdef SERIAL_PARITY_ODD_EN
        return ~(^d);
`else
        return ^d;
`endif
    endfunction

    // Monitor: sample mid-cycle, pop the scoreboard on every accepted frame.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) valid_cycles++;
            if (ovr_err) ovr_count++;
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_frame: got data=%h par=%b frm=%b, required no frame",
                             out_data, par_err, frm_err);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if ({out_data, par_err, frm_err} !== mon_exp)
                        $display("FAIL frame_data: got data=%h par=%b frm=%b, required data=%h par=%b frm=%b",
                                 out_data, par_err, frm_err, mon_exp.data, mon_exp.par_err, mon_exp.frm_err);
                    else
                        passed++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input int gap);
        for (int i = 0; i < gap; i++) begin
            rx_valid = 1'b0;
            rx_bit   = 1'($urandom_range(0, 1));
            tick();
        end
        rx_valid = 1'b1;
        rx_bit   = b;
        tick();
        rx_valid = 1'b0;
        rx_bit   = 1'b1;
    endtask

    task automatic send_frame(input logic [DATA_W-1:0] d, input logic p, input logic stop,
                              input int gap, input bit deliver, input bit ready_at_stop);
        send_bit(1'b0, gap);
        for (int i = 0; i < DATA_W; i++) send_bit(d[i], gap);
        send_bit(p, gap);
        if (deliver) exp_q.push_back({d, exp_par_err(d, p), ~stop});
        if (ready_at_stop) out_ready = 1'b1;
        send_bit(stop, gap);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 30 && exp_q.size() != 0; i++) tick();
        tick();
        tick();
        checks++;
        if (exp_q.size() != 0)
            $display("FAIL %s_drain: got %0d frames pending, required 0", name, exp_q.size());
        else
            passed++;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({out_valid, busy, ovr_err} !== 3'b000)
            $display("FAIL reset_flags: got valid=%b busy=%b ovr=%b, required 0 0 0", out_valid, busy, ovr_err);
        else passed++;
        checks++;
        if ({out_data, par_err, frm_err} !== '0)
            $display("FAIL reset_data: got data=%h par=%b frm=%b, required 00 0 0", out_data, par_err, frm_err);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_good_frame();
        out_ready    = 1'b1;
        valid_cycles = 0;
        send_frame(8'hA5, 1'b0 ^ good_parity(8'hA5) ^ good_parity(8'hA5) ^ good_parity(8'hA5) ^ 1'b0 ^ good_parity(8'hA5) ^ good_parity(8'hA5) ^ good_parity(8'hA5),
                   1'b1, 0, 1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5)
            $display("FAIL good_valid_rise: got valid=%b data=%h, required 1 a5", out_valid, out_data);
        else passed++;
        checks++;
        if (busy !== 1'b0)
            $display("FAIL good_busy_idle: got %b, required 0", busy);
        else passed++;
        drain("good");
        checks++;
        if (valid_cycles != 1)
            $display("FAIL good_valid_cycles: got %0d, required 1", valid_cycles);
        else passed++;
    endtask

    task automatic test_parity_err();
        out_ready = 1'b1;
        send_frame(8'h07, 1'b0, 1'b1, 0, 1'b1, 1'b0);
        checks++;
        if (par_err !== exp_par_err(8'h07, 1'b0) || frm_err !== 1'b0 || out_data !== 8'h07)
            $display("FAIL parity_flags: got par=%b frm=%b data=%h, required par=%b frm=0 data=07",
                     par_err, frm_err, out_data, exp_par_err(8'h07, 1'b0));
        else passed++;
        drain("parity");
    endtask

    task automatic test_framing_err();
        out_ready = 1'b1;
        send_frame(8'h3C, good_parity(8'h3C), 1'b0, 2, 1'b1, 1'b0);
        checks++;
        if (frm_err !== 1'b1 || par_err !== 1'b0 || out_data !== 8'h3C)
            $display("FAIL framing_flags: got frm=%b par=%b data=%h, required 1 0 3c", frm_err, par_err, out_data);
        else passed++;
        drain("framing");
    endtask

    task automatic test_overrun();
        int ovr_base;
        out_ready = 1'b0;
        ovr_base  = ovr_count;
        send_frame(8'h11, good_parity(8'h11), 1'b1, 0, 1'b1, 1'b0);
        send_frame(8'h22, good_parity(8'h22), 1'b1, 1, 1'b0, 1'b0);
        checks++;
        if (ovr_err !== 1'b1 || out_data !== 8'h11)
            $display("FAIL overrun_pulse: got ovr=%b data=%h, required 1 11", ovr_err, out_data);
        else passed++;
        tick();
        checks++;
        if (ovr_err !== 1'b0)
            $display("FAIL overrun_one_cycle: got %b, required 0", ovr_err);
        else passed++;
        repeat (3) tick();
        checks++;
        if (ovr_count - ovr_base != 1 || out_valid !== 1'b1 || out_data !== 8'h11)
            $display("FAIL overrun_hold: got pulses=%0d valid=%b data=%h, required 1 1 11",
                     ovr_count - ovr_base, out_valid, out_data);
        else passed++;
        out_ready = 1'b1;
        drain("overrun");
        checks++;
        if (out_valid !== 1'b0)
            $display("FAIL overrun_release: got valid=%b, required 0", out_valid);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int ovr_base;
        out_ready = 1'b0;
        ovr_base  = ovr_count;
        send_frame(8'h11, good_parity(8'h11), 1'b1, 0, 1'b1, 1'b0);
        send_frame(8'h22, good_parity(8'h22), 1'b1, 0, 1'b1, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h22 || ovr_err !== 1'b0)
            $display("FAIL b2b_reload: got valid=%b data=%h ovr=%b, required 1 22 0", out_valid, out_data, ovr_err);
        else passed++;
        drain("b2b");
        checks++;
        if (ovr_count != ovr_base)
            $display("FAIL b2b_no_overrun: got %0d pulses, required 0", ovr_count - ovr_base);
        else passed++;
    endtask

    task automatic test_reset_mid_frame();
        int valid_base;
        out_ready = 1'b1;
        send_bit(1'b0, 0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 0);
        checks++;
        if (busy !== 1'b1)
            $display("FAIL midreset_busy_before: got %b, required 1", busy);
        else passed++;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0)
            $display("FAIL midreset_async: got busy=%b valid=%b, required 0 0", busy, out_valid);
        else passed++;
        @(negedge clk);
        rst_n      = 1'b1;
        valid_base = valid_cycles;
        send_frame(8'h5A, good_parity(8'h5A), 1'b1, 0, 1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h5A || par_err !== 1'b0 || frm_err !== 1'b0)
            $display("FAIL midreset_next_frame: got valid=%b data=%h par=%b frm=%b, required 1 5a 0 0",
                     out_valid, out_data, par_err, frm_err);
        else passed++;
        drain("midreset");
        checks++;
        if (valid_cycles - valid_base != 1)
            $display("FAIL midreset_valid_cycles: got %0d, required 1", valid_cycles - valid_base);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_parity_err();
        test_framing_err();
        test_overrun();
        test_back_to_back();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
